// File: rtl/mult_limb_arbiter_pkg.sv
// Purpose : shared types and defaults for the limb-multiplier arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mult_arb_pkg;

    localparam int A_BITS_DEF = 130;
    localparam int B_BITS_DEF = 128;
    localparam int P_BITS_DEF = A_BITS_DEF + B_BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_limb_arbiter_rr_pick.sv
// Purpose : round-robin pick; first set bit of req at or above ptr, wrapping.
// Latency : combinational.
// Backpressure: none; pure function of req and ptr.
// Ports   : req (request vector), ptr (search start), gnt (one-hot),
//           idx (binary index of gnt), any (at least one request).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Two passes with last-write-wins: the wrapped requesters (below ptr)
    // are considered first so that any requester at or above ptr overrides
    // them; within each pass the downward loop leaves the lowest index.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(ptr))) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mult_limb_arbiter.sv
// Purpose : shares one serial 130x128 limb multiplier among NUM_REQ requesters, round-robin.
// Latency : accept -> start 1 cycle; rsp_valid one edge after mul_done; next accept 1 cycle after rsp handshake.
// Backpressure: one op in flight; req_ready is 0 outside IDLE; DELIVER holds until owner's rsp_ready.
// Ports   : req_valid/req_ready/req_a/req_b   request side (packed operand slices)
//           rsp_valid/rsp_ready/rsp_product   response side (one-hot valid, shared product bus)
//           mul_start/mul_a/mul_b/mul_busy/mul_done/mul_product  multiplier side
//           arb_busy, owner_id, stray_done     status (stray_done sticky until reset)
module mult_limb_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int A_BITS  = A_BITS_DEF,
    parameter  int B_BITS  = B_BITS_DEF,
    localparam int P_BITS  = A_BITS + B_BITS,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*A_BITS-1:0]   req_a,
    input  logic [NUM_REQ*B_BITS-1:0]   req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [P_BITS-1:0]           rsp_product,
    output logic                        mul_start,
    output logic [A_BITS-1:0]           mul_a,
    output logic [B_BITS-1:0]           mul_b,
    input  logic                        mul_busy,
    input  logic                        mul_done,
    input  logic [P_BITS-1:0]           mul_product,
    output logic                        arb_busy,
    output logic [ID_W-1:0]             owner_id,
    output logic                        stray_done
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;
    logic                 owner_ack;
    logic                 accept;
    logic                 capture;
    logic                 release_rsp;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the owner's rsp_ready matters; other requesters are ignored.
    assign owner_ack   = rsp_ready[owner_id];
    assign accept      = (state_q == ST_IDLE) && pick_any;
    assign capture     = (state_q == ST_WAIT) && mul_done;
    assign release_rsp = (state_q == ST_DELIVER) && owner_ack;
    assign arb_busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Start only once the multiplier is free; the pulse lasts
                // exactly one cycle because we leave ISSUE on the same edge.
                if (!mul_busy) begin
                    mul_start = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (owner_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a       <= '0;
            mul_b       <= '0;
            owner_id    <= '0;
            rsp_product <= '0;
            rsp_valid   <= '0;
            rr_ptr_q    <= '0;
            stray_done  <= 1'b0;
        end else begin
            if (accept) begin
                mul_a    <= req_a[pick_idx*A_BITS +: A_BITS];
                mul_b    <= req_b[pick_idx*B_BITS +: B_BITS];
                owner_id <= pick_idx;
            end
            if (capture) begin
                rsp_product <= mul_product;
                rsp_valid   <= NUM_REQ'(1) << owner_id;
            end
            if (release_rsp) begin
                rsp_valid <= '0;
                // Next search starts just past the requester served last.
                rr_ptr_q  <= (int'(owner_id) == NUM_REQ - 1) ? '0 : owner_id + 1'b1;
            end
            if (mul_done && (state_q != ST_WAIT)) begin
                stray_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_limb_arbiter.sv
// Purpose : directed bench for mult_limb_arbiter with a latency-matched multiplier model.
// Latency : model raises done B_BITS+1 edges after it samples start.
// Backpressure: bench drives rsp_ready and can hold mul_busy to stall the issue.
module tb_mult_limb_arbiter;

    localparam int N  = 4;
    localparam int AB = 130;
    localparam int BB = 128;
    localparam int PB = AB + BB;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AB-1:0]   req_a = '0;
    logic [N*BB-1:0]   req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '0;
    logic [PB-1:0]     rsp_product;
    logic              mul_start;
    logic [AB-1:0]     mul_a;
    logic [BB-1:0]     mul_b;
    logic              mul_busy;
    logic              mul_done;
    logic [PB-1:0]     mul_product;
    logic              arb_busy;
    logic [1:0]        owner_id;
    logic              stray_done;

    logic              m_busy;
    logic [7:0]        m_cnt;
    logic [PB-1:0]     m_prod;
    logic              inj_busy = 1'b0;
    logic              inj_done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_limb_arbiter #(.NUM_REQ(N), .A_BITS(AB), .B_BITS(BB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .arb_busy    (arb_busy),
        .owner_id    (owner_id),
        .stray_done  (stray_done)
    );

    // Serial multiplier stand-in: product ready, done pulses B_BITS+1 edges after start.
    assign mul_busy    = m_busy | inj_busy;
    assign mul_done    = (m_busy && (m_cnt == 8'd0)) | inj_done;
    assign mul_product = m_prod;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
            m_prod <= '0;
        end else if (mul_start && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'(BB);
            m_prod <= PB'(mul_a) * PB'(mul_b);
        end else if (m_busy) begin
            if (m_cnt == 8'd0) m_busy <= 1'b0;
            else               m_cnt  <= m_cnt - 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [PB-1:0] act, input logic [PB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One full transaction starting in IDLE. Call just after a negedge with
    // req_valid already driven. busy_cyc stalls ISSUE, hold_cyc delays rsp_ready.
    task automatic serve(input int busy_cyc, input int hold_cyc,
                         output int who, output int rsp_idx,
                         output logic [PB-1:0] prod, output int lat);
        int n;
        logic first;
        logic [N-1:0] gnt;
        logic [N-1:0] v0;
        logic [PB-1:0] p0;
        who = -1; rsp_idx = -1; prod = '0; lat = 0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready == '0) begin
            chk("grant_timeout", 1, 0);
            return;
        end
        gnt = req_ready;
        who = oh_idx(gnt);
        inj_busy = (busy_cyc > 0);
        @(negedge clk); #1;
        req_valid = req_valid & ~gnt;
        chk("owner_id", PB'(owner_id), PB'(who));
        for (int k = 0; k < busy_cyc; k++) begin
            chk("issue_stall_start", PB'(mul_start), 0);
            chk("issue_stall_ready", PB'(req_ready), 0);
            @(negedge clk); #1;
        end
        inj_busy = 1'b0;
        #1;
        chk("start_pulse", PB'(mul_start), 1);
        n = busy_cyc;
        first = 1'b1;
        while (rsp_valid == '0 && n < 600) begin
            @(negedge clk); #1; n++;
            if (first) begin
                chk("start_one_cycle", PB'(mul_start), 0);
                first = 1'b0;
            end
        end
        if (rsp_valid == '0) begin
            chk("rsp_timeout", 1, 0);
            return;
        end
        rsp_idx = oh_idx(rsp_valid);
        prod = rsp_product;
        lat = n;
        v0 = rsp_valid;
        p0 = rsp_product;
        for (int k = 0; k < hold_cyc; k++) begin
            rsp_ready = ~rsp_valid;
            @(negedge clk); #1;
            chk("hold_valid", PB'(rsp_valid), PB'(v0));
            chk("hold_product", rsp_product, p0);
            chk("hold_req_ready", PB'(req_ready), 0);
        end
        rsp_ready = rsp_valid;
        @(negedge clk); #1;
        rsp_ready = '0;
        chk("rsp_cleared", PB'(rsp_valid), 0);
        chk("idle_after_ack", PB'(arb_busy), 0);
    endtask

    int who, ridx, lat;
    logic [PB-1:0] prod;
    logic [PB-1:0] max_exp;
    logic seen;

    initial begin
        // Reset from time 1 so the async reset sees a falling edge.
        #1 reset_n = 1'b0;
        #1;
        chk("rst_req_ready", PB'(req_ready), 0);
        chk("rst_rsp_valid", PB'(rsp_valid), 0);
        chk("rst_mul_start", PB'(mul_start), 0);
        chk("rst_arb_busy", PB'(arb_busy), 0);
        chk("rst_owner", PB'(owner_id), 0);
        chk("rst_stray", PB'(stray_done), 0);
        chk("rst_mul_a", PB'(mul_a), 0);
        chk("rst_product", rsp_product, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); #1;

        // Single request 3*5.
        req_a[0 +: AB] = 130'd3;
        req_b[0 +: BB] = 128'd5;
        req_valid = 4'b0001;
        #1 chk("single_ready_same_cycle", PB'(req_ready), 4'b0001);
        serve(0, 0, who, ridx, prod, lat);
        chk("single_who", PB'(who), 0);
        chk("single_rsp_idx", PB'(ridx), 0);
        chk("single_product", prod, 15);
        chk("single_latency", PB'(lat), BB + 2);
        chk("single_mul_a", PB'(mul_a), 3);
        chk("single_mul_b", PB'(mul_b), 5);

        // All four from reset: a=i+1, b=2, served in index order.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; #1;
        for (int i = 0; i < N; i++) begin
            req_a[i*AB +: AB] = AB'(i + 1);
            req_b[i*BB +: BB] = BB'(2);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            serve(0, 0, who, ridx, prod, lat);
            chk("all4_who", PB'(who), PB'(i));
            chk("all4_rsp_idx", PB'(ridx), PB'(i));
            chk("all4_product", prod, PB'(2 * (i + 1)));
        end

        // Req1 and req2 both keep requesting: must alternate 1,2,1,2.
        req_a[1*AB +: AB] = 130'd7; req_b[1*BB +: BB] = 128'd1;
        req_a[2*AB +: AB] = 130'd9; req_b[2*BB +: BB] = 128'd1;
        for (int r = 0; r < 4; r++) begin
            req_valid = 4'b0110;
            serve(0, 0, who, ridx, prod, lat);
            chk("alt_who", PB'(who), (r % 2 == 0) ? 1 : 2);
            chk("alt_product", prod, (r % 2 == 0) ? 7 : 9);
        end
        req_valid = '0;

        // Busy multiplier stalls ISSUE, then 10 cycles of response backpressure.
        // rr_ptr is 3, so req0 wins over req1.
        req_a[0 +: AB] = 130'd11; req_b[0 +: BB] = 128'd13;
        req_a[1*AB +: AB] = 130'd2; req_b[1*BB +: BB] = 128'd3;
        req_valid = 4'b0011;
        serve(3, 10, who, ridx, prod, lat);
        chk("bp_who", PB'(who), 0);
        chk("bp_product", prod, 143);
        chk("bp_next_grant", PB'(req_ready), 4'b0010);
        serve(0, 0, who, ridx, prod, lat);
        chk("bp_req1_who", PB'(who), 1);
        chk("bp_req1_product", prod, 6);

        // Full-width operands.
        req_a[2*AB +: AB] = '1;
        req_b[2*BB +: BB] = '1;
        max_exp = '0;
        max_exp = max_exp - (PB'(1) << 130) - (PB'(1) << 128) + PB'(1);
        req_valid = 4'b0100;
        serve(0, 0, who, ridx, prod, lat);
        chk("max_who", PB'(who), 2);
        chk("max_product", prod, max_exp);

        // Reset in the middle of WAIT.
        req_a[0 +: AB] = 130'd5; req_b[0 +: BB] = 128'd5;
        req_valid = 4'b0001;
        #1 chk("rstw_grant", PB'(req_ready), 4'b0001);
        @(negedge clk); #1;
        req_valid = '0;
        repeat (20) @(negedge clk);
        #1 chk("rstw_in_flight", PB'(arb_busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rstw_rsp_valid", PB'(rsp_valid), 0);
        chk("rstw_arb_busy", PB'(arb_busy), 0);
        chk("rstw_owner", PB'(owner_id), 0);
        chk("rstw_mul_a", PB'(mul_a), 0);
        chk("rstw_mul_b", PB'(mul_b), 0);
        chk("rstw_product", rsp_product, 0);
        chk("rstw_start", PB'(mul_start), 0);
        @(negedge clk); reset_n = 1'b1;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk); #1;
            if (rsp_valid != '0 || arb_busy) seen = 1'b1;
        end
        chk("rstw_no_response", PB'(seen), 0);
        chk("rstw_no_stray", PB'(stray_done), 0);

        // Stray done in IDLE: sticky, and the arbiter still works.
        inj_done = 1'b1;
        @(negedge clk); #1;
        inj_done = 1'b0;
        chk("stray_set", PB'(stray_done), 1);
        repeat (5) @(negedge clk);
        #1 chk("stray_sticky", PB'(stray_done), 1);
        req_a[3*AB +: AB] = 130'd4; req_b[3*BB +: BB] = 128'd6;
        req_valid = 4'b1000;
        serve(0, 0, who, ridx, prod, lat);
        chk("stray_after_who", PB'(who), 3);
        chk("stray_after_product", prod, 24);
        chk("stray_still_set", PB'(stray_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
